// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: stage enables/flushes, memory-wait and halt sequencing, stall counter.
// Define HAZARD_FWD_EN when forwarding exists, so that only load-use dependencies stall.
module hazard_scheduler (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ihit,
    input  logic       i_dhit,
    input  logic       i_mem_dreq,
    input  logic       i_mem_datomic,
    input  logic       i_mem_halt,
    input  logic [4:0] i_id_rsel1,
    input  logic [4:0] i_id_rsel2,
    input  logic [4:0] i_ex_wsel,
    input  logic       i_ex_RegWrite,
    input  logic       i_ex_MemRead,
    input  logic [4:0] i_mem_wsel,
    input  logic       i_mem_RegWrite,
    input  logic       i_ex_pc_mux,
    output logic       o_pc_en,
    output logic       o_ifid_en,
    output logic       o_idex_en,
    output logic       o_exmem_en,
    output logic       o_memwb_en,
    output logic       o_ifid_flush,
    output logic       o_idex_flush,
    output logic       o_halt_out,
    output logic [15:0] o_stall_cnt
);

    typedef enum logic [1:0] {ST_RUN, ST_MEMWAIT, ST_ATOMIC, ST_HALTED} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_halt;
    logic [15:0] r_stall_cnt;
    logic        w_raw;
    logic        w_ex_match;
    logic        w_adv;

    // Register $0 is hardwired to zero, so a write to it never creates a dependency.
    assign w_ex_match = (i_ex_wsel != 5'd0) &&
                        ((i_ex_wsel == i_id_rsel1) || (i_ex_wsel == i_id_rsel2));

`ifdef HAZARD_FWD_EN
    logic w_unused;
    assign w_unused = &{1'b0, i_mem_wsel, i_mem_RegWrite};
    assign w_raw    = i_ex_MemRead & i_ex_RegWrite & w_ex_match;
`else
    logic w_mem_match;
    logic w_unused;
    assign w_unused    = i_ex_MemRead;
    assign w_mem_match = (i_mem_wsel != 5'd0) &&
                         ((i_mem_wsel == i_id_rsel1) || (i_mem_wsel == i_id_rsel2));
    assign w_raw       = (i_ex_RegWrite & w_ex_match) | (i_mem_RegWrite & w_mem_match);
`endif

    always_comb begin
        w_next       = r_state;
        w_adv        = 1'b0;
        o_pc_en      = 1'b0;
        o_ifid_en    = 1'b0;
        o_idex_en    = 1'b0;
        o_exmem_en   = 1'b0;
        o_memwb_en   = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (i_mem_halt)                                 w_next = ST_HALTED;
                else if (i_mem_dreq && !i_dhit)                 w_next = ST_MEMWAIT;
                else if (i_mem_dreq && i_dhit && i_mem_datomic) w_next = ST_ATOMIC;
                else                                            w_adv  = 1'b1;
            end
            ST_MEMWAIT: begin
                if (i_dhit && i_mem_datomic) begin
                    w_next = ST_ATOMIC;
                end else if (i_dhit) begin
                    w_adv  = 1'b1;
                    w_next = ST_RUN;
                end
            end
            ST_ATOMIC: begin
                w_adv  = 1'b1;
                w_next = ST_RUN;
            end
            ST_HALTED: w_next = ST_HALTED;
            default:   w_next = ST_RUN;
        endcase

        // A taken branch squashes the wrong-path instructions, which also clears any RAW stall.
        if (w_adv) begin
            o_ifid_en  = 1'b1;
            o_idex_en  = 1'b1;
            o_exmem_en = 1'b1;
            o_memwb_en = 1'b1;
            if (i_ex_pc_mux) begin
                o_pc_en      = i_ihit;
                o_ifid_flush = 1'b1;
                o_idex_flush = 1'b1;
            end else if (w_raw) begin
                o_ifid_en    = 1'b0;
                o_idex_flush = 1'b1;
            end else if (!i_ihit) begin
                o_ifid_flush = 1'b1;
            end else begin
                o_pc_en = 1'b1;
            end
        end

        if (i_rst) begin
            o_pc_en      = 1'b0;
            o_ifid_en    = 1'b0;
            o_idex_en    = 1'b0;
            o_exmem_en   = 1'b0;
            o_memwb_en   = 1'b0;
            o_ifid_flush = 1'b0;
            o_idex_flush = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_halt      <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state <= w_next;
            r_halt  <= (w_next == ST_HALTED);
            if (!o_pc_en && (r_state != ST_HALTED) && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_halt_out  = r_halt;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Testbench for hazard_scheduler: directed vectors, a per-cycle reference model and literal spot checks.
module tb_hazard_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       ihit, dhit, mem_dreq, mem_datomic, mem_halt;
    logic [4:0] id_rsel1, id_rsel2, ex_wsel, mem_wsel;
    logic       ex_RegWrite, ex_MemRead, mem_RegWrite, ex_pc_mux;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt_out;
    logic [15:0] stall_cnt;

    int testsRun = 0;
    int testsFailed = 0;

    localparam int M_RUN = 0, M_WAIT = 1, M_ATOMIC = 2, M_HALTED = 3;
    int          mMode = M_RUN;
    logic        mHalt = 1'b0;
    int          mCnt  = 0;

    hazard_scheduler dut (
        .i_clk(clk), .i_rst(rst), .i_ihit(ihit), .i_dhit(dhit),
        .i_mem_dreq(mem_dreq), .i_mem_datomic(mem_datomic), .i_mem_halt(mem_halt),
        .i_id_rsel1(id_rsel1), .i_id_rsel2(id_rsel2), .i_ex_wsel(ex_wsel),
        .i_ex_RegWrite(ex_RegWrite), .i_ex_MemRead(ex_MemRead),
        .i_mem_wsel(mem_wsel), .i_mem_RegWrite(mem_RegWrite), .i_ex_pc_mux(ex_pc_mux),
        .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_idex_en(idex_en), .o_exmem_en(exmem_en),
        .o_memwb_en(memwb_en), .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush),
        .o_halt_out(halt_out), .o_stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A dependency exists when either producer writes a nonzero register the ID stage reads.
    function automatic bit modelRaw();
        bit exDep, memDep;
        exDep  = ex_wsel != 0 && (ex_wsel == id_rsel1 || ex_wsel == id_rsel2);
        memDep = mem_wsel != 0 && (mem_wsel == id_rsel1 || mem_wsel == id_rsel2);
`ifdef HAZARD_FWD_EN
        return ex_MemRead && ex_RegWrite && exDep;
`else
        return (ex_RegWrite && exDep) || (mem_RegWrite && memDep);
`endif
    endfunction

    // Outputs listed as {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}.
    function automatic logic [6:0] modelAdvance();
        if (ex_pc_mux)   return {ihit, 6'b111111};
        if (modelRaw())  return 7'b0011101;
        if (!ihit)       return 7'b0111110;
        return 7'b1111100;
    endfunction

    // Reference model: checks outputs mid-cycle, then advances to the post-edge state.
    always @(negedge clk) begin
        logic [6:0] exp;
        int nxt;
        if (rst) begin
            mMode = M_RUN; mHalt = 1'b0; mCnt = 0;
            checkOutput("reset outputs", {9'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}, 16'd0);
            checkOutput("reset halt_out", {15'd0, halt_out}, 16'd0);
            checkOutput("reset stall_cnt", stall_cnt, 16'd0);
        end else begin
            exp = 7'b0;
            nxt = mMode;
            if (mMode == M_RUN) begin
                if (mem_halt)                             nxt = M_HALTED;
                else if (mem_dreq && !dhit)               nxt = M_WAIT;
                else if (mem_dreq && dhit && mem_datomic) nxt = M_ATOMIC;
                else                                      exp = modelAdvance();
            end else if (mMode == M_WAIT) begin
                if (dhit && mem_datomic) nxt = M_ATOMIC;
                else if (dhit) begin exp = modelAdvance(); nxt = M_RUN; end
            end else if (mMode == M_ATOMIC) begin
                exp = modelAdvance(); nxt = M_RUN;
            end
            checkOutput("enables/flushes", {9'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}, {9'd0, exp});
            checkOutput("halt_out", {15'd0, halt_out}, {15'd0, mHalt});
            checkOutput("stall_cnt", stall_cnt, mCnt[15:0]);
            if (!exp[6] && mMode != M_HALTED && mCnt < 65535) mCnt++;
            mHalt = (nxt == M_HALTED);
            mMode = nxt;
        end
    end

    task automatic setIdle();
        rst = 0; ihit = 1; dhit = 0; mem_dreq = 0; mem_datomic = 0; mem_halt = 0;
        id_rsel1 = 5'd1; id_rsel2 = 5'd2; ex_wsel = 5'd7; mem_wsel = 5'd8;
        ex_RegWrite = 1; ex_MemRead = 0; mem_RegWrite = 1; ex_pc_mux = 0;
    endtask

    // Holds the current inputs for n clock edges, returning just after the last edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        setIdle();
        rst = 1;
        #1;
        checkOutput("lit reset stall_cnt", stall_cnt, 16'd0);
        checkOutput("lit reset pc_en", {15'd0, pc_en}, 16'd0);
        applyStimulus(2);
        rst = 0;
        applyStimulus(3);

        ex_MemRead = 1; ex_wsel = 5'd5; id_rsel1 = 5'd5;
        #1;
        checkOutput("lit load-use pc_en", {15'd0, pc_en}, 16'd0);
        checkOutput("lit load-use ifid_en", {15'd0, ifid_en}, 16'd0);
        checkOutput("lit load-use idex_flush", {15'd0, idex_flush}, 16'd1);
        applyStimulus(1);
        checkOutput("lit load-use stall_cnt", stall_cnt, 16'd1);

        setIdle(); mem_wsel = 5'd3; id_rsel2 = 5'd3;
        applyStimulus(1);
`ifdef HAZARD_FWD_EN
        checkOutput("lit mem dep stall_cnt", stall_cnt, 16'd1);
`else
        checkOutput("lit mem dep stall_cnt", stall_cnt, 16'd2);
`endif
        mem_wsel = 5'd0; id_rsel2 = 5'd0;
        #1;
        checkOutput("lit reg0 pc_en", {15'd0, pc_en}, 16'd1);
        applyStimulus(1);
        ex_wsel = 5'd0; id_rsel1 = 5'd0; ex_MemRead = 1;
        applyStimulus(1);

        setIdle(); ihit = 0;
        #1;
        checkOutput("lit miss ifid_flush", {15'd0, ifid_flush}, 16'd1);
        applyStimulus(1);

        setIdle(); rst = 1;
        #1;
        checkOutput("lit async clear stall_cnt", stall_cnt, 16'd0);
        applyStimulus(1);
        rst = 0;

        mem_dreq = 1; dhit = 0;
        applyStimulus(3);
        dhit = 1;
        #1;
        checkOutput("lit memwait release pc_en", {15'd0, pc_en}, 16'd1);
        applyStimulus(1);
        checkOutput("lit memwait stall_cnt", stall_cnt, 16'd3);

        mem_dreq = 1; dhit = 1; mem_datomic = 1;
        applyStimulus(1);
        dhit = 0;
        #1;
        checkOutput("lit atomic pc_en", {15'd0, pc_en}, 16'd1);
        applyStimulus(1);
        setIdle();
        applyStimulus(1);
        checkOutput("lit atomic stall_cnt", stall_cnt, 16'd4);

        mem_dreq = 1; mem_datomic = 1; dhit = 0;
        applyStimulus(1);
        dhit = 1;
        applyStimulus(1);
        dhit = 0;
        applyStimulus(1);
        setIdle();

        ex_pc_mux = 1; ex_MemRead = 1; ex_wsel = 5'd5; id_rsel1 = 5'd5;
        #1;
        checkOutput("lit branch+raw outs", {9'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}, 16'h7F);
        applyStimulus(1);
        ihit = 0;
        applyStimulus(1);
        ex_pc_mux = 0;
        applyStimulus(1);
        checkOutput("lit branch stall_cnt", stall_cnt, 16'd8);

        setIdle(); mem_dreq = 1;
        applyStimulus(1);
        rst = 1; mem_dreq = 0;
        applyStimulus(1);
        rst = 0;
        applyStimulus(2);
        checkOutput("lit abort memwait stall_cnt", stall_cnt, 16'd0);
        mem_dreq = 1; dhit = 1; mem_datomic = 1;
        applyStimulus(1);
        setIdle(); rst = 1;
        applyStimulus(1);
        rst = 0;
        applyStimulus(2);

        mem_halt = 1;
        #1;
        checkOutput("lit halt pc_en", {15'd0, pc_en}, 16'd0);
        checkOutput("lit halt_out before edge", {15'd0, halt_out}, 16'd0);
        applyStimulus(1);
        checkOutput("lit halt_out after edge", {15'd0, halt_out}, 16'd1);
        mem_halt = 0;
        applyStimulus(3);
        checkOutput("lit halted halt_out", {15'd0, halt_out}, 16'd1);
        checkOutput("lit halted stall_cnt", stall_cnt, 16'd1);
        rst = 1;
        #1;
        checkOutput("lit halt cleared", {15'd0, halt_out}, 16'd0);
        applyStimulus(1);
        rst = 0;
        applyStimulus(2);
        checkOutput("lit run after halt", {15'd0, pc_en}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
